rtc_bus_reader: RTL and testbench
=================================

// Module: rtc_bus_reader
// PURPOSE
//   Initiator side of the RTC register path. Scans a fixed list of 11 RTC registers on the
//   RTC's multiplexed address/data bus: time/date 0x21-0x28, timer 0x41-0x43.
//   Republishes each value on the address/AoD/data_vga interface to the display register bank.
//   That bank writes data_vga whenever address matches and AoD=0, so this block keeps AoD=1
//   except on a single capture cycle per register.
// PARAMETERS
//   T_ADDR  4  cycles ale/address held on bus (1..255)
//   T_RD    6  cycles rd_n held low; ad_in sampled on last cycle (1..255)
//   T_GAP   4  cycles cs_n high between registers (1..255)
// PORTS
//   clk       in   1  system clock, all logic on posedge
//   reset_n   in   1  asynchronous active-low reset
//   scan_req  in   1  level; start a scan when sampled high in IDLE
//   ad_in     in   8  RTC bus read data
//   ad_out    out  8  RTC bus drive value (address phase)
//   ad_oe     out  1  1 = drive ad_out onto RTC bus
//   cs_n      out  1  RTC chip select, active low
//   ale       out  1  RTC address latch strobe, active high
//   rd_n      out  1  RTC read strobe, active low
//   address   out  8  register address to display register bank
//   AoD       out  1  1 = address/hold, 0 = data_vga valid (one-cycle capture)
//   data_vga  out  8  captured register value
//   busy      out  1  1 when state != IDLE
//   scan_done out  1  one-cycle pulse after last register captured
// BEHAVIOUR
//   Reset (async, immediate, any state): state=IDLE, idx=0, ad_out=0, ad_oe=0, cs_n=1, ale=0,
//     rd_n=1, address=8'h00, AoD=1, data_vga=0, busy=0, scan_done=0.
//   Address table: idx 0..7 -> 8'h21..8'h28; idx 8..10 -> 8'h41..8'h43.
//   States (8-bit down counter cnt loaded on entry; leave when cnt reaches its final value):
//     IDLE : all strobes inactive. If scan_req=1: idx=0, go ADDR next cycle.
//     ADDR : T_ADDR cycles; cs_n=0, ale=1, ad_oe=1, ad_out=table[idx];
//            address=table[idx] from first ADDR cycle; AoD=1.
//     TURN : 1 cycle; ale=0, ad_oe=0, cs_n=0 (bus turnaround).
//     READ : T_RD cycles; rd_n=0, cs_n=0. data_vga<=ad_in on last READ cycle only.
//     CAPT : 1 cycle; rd_n=1, cs_n=0, AoD=0, address/data_vga stable.
//     GAP  : T_GAP cycles; cs_n=1, AoD=1. Then if idx<10: idx+1, ADDR; else DONE.
//     DONE : 1 cycle; scan_done=1, cs_n=1. Then IDLE.
//   Per-register time = T_ADDR+T_RD+T_GAP+2 (16 at defaults).
//   Full scan, first ADDR to DONE inclusive = 11*16+1 = 177 cycles.
//   address and data_vga hold their last values in IDLE/DONE and across GAP.
//   AoD=0 exactly 11 cycles per scan, never two consecutive cycles.
//   scan_req ignored outside IDLE; held high -> next scan starts after one IDLE cycle.
//   ad_oe and rd_n=0 never simultaneously true. ale=1 only while ad_oe=1.
//   Reset mid-scan aborts with no capture. After release, a scan starts at idx 0 (8'h21).
// TESTING
//   Reset: hold reset_n=0 -> all outputs at reset values; AoD=1, cs_n=1, busy=0.
//   Single scan: RTC model returns ~addr; one scan_req pulse -> 11 CAPT cycles.
//     Each CAPT: address=21..28,41..43; data_vga=DE,DD..D7,BE,BD,BC.
//     scan_done 177 cycles after first ADDR.
//   Timing: check ale width=4, rd_n low width=6, cs_n high gap=4.
//     ad_oe=0 whenever rd_n=0. AoD low exactly 1 cycle per register.
//   Back-to-back: scan_req held 1 -> second ADDR(0x21) follows DONE after exactly one IDLE cycle.
//   Busy ignore: pulse scan_req at register 0x25 -> scan unaffected; one scan_done only.
//   Abort: reset_n=0 during READ of 0x42 -> rd_n=1, cs_n=1, AoD=1 same cycle; no capture.
//     Release + scan_req -> restarts at 0x21.

Source files
------------

// File: rtl/rtc_bus_reader_if.sv
// Bus bundle for rtc_bus_reader: RTC multiplexed address/data strobes plus the
// display register bank address/AoD/data_vga path and scan control.
interface rtc_bus_reader_if;
    logic       scan_req;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic [7:0] address;
    logic       AoD;
    logic [7:0] data_vga;
    logic       busy;
    logic       scan_done;

    modport master (
        input  scan_req, ad_in,
        output ad_out, ad_oe, cs_n, ale, rd_n, address, AoD, data_vga, busy, scan_done
    );

    modport slave (
        output scan_req, ad_in,
        input  ad_out, ad_oe, cs_n, ale, rd_n, address, AoD, data_vga, busy, scan_done
    );
endinterface

// File: rtl/rtc_bus_reader.sv
// Scans 11 RTC registers over the multiplexed bus and republishes each value to the
// display register bank with a single AoD=0 capture cycle per register.
module rtc_bus_reader #(
    parameter int unsigned T_ADDR = 4,
    parameter int unsigned T_RD   = 6,
    parameter int unsigned T_GAP  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    rtc_bus_reader_if.master bus
);

    localparam int unsigned LAST_IDX = 10;
    localparam logic [7:0]  CNT_ADDR = 8'(T_ADDR - 1);
    localparam logic [7:0]  CNT_RD   = 8'(T_RD - 1);
    localparam logic [7:0]  CNT_GAP  = 8'(T_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TURN,
        S_READ,
        S_CAPT,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_n_q, cs_n_d;
    logic       ale_q, ale_d;
    logic       rd_n_q, rd_n_d;
    logic [7:0] address_q, address_d;
    logic       aod_q, aod_d;
    logic [7:0] data_vga_q, data_vga_d;
    logic       busy_q, busy_d;
    logic       scan_done_q, scan_done_d;

    // idx 0..7 -> time/date 0x21..0x28, idx 8..10 -> timer 0x41..0x43
    function automatic logic [7:0] reg_addr(input logic [3:0] i);
        if (i < 4'd8) begin
            return 8'h21 + 8'(i);
        end
        return 8'h41 + 8'(i - 4'd8);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'h00;
            idx_q       <= 4'd0;
            ad_out_q    <= 8'h00;
            ad_oe_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            ale_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            address_q   <= 8'h00;
            aod_q       <= 1'b1;
            data_vga_q  <= 8'h00;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            cs_n_q      <= cs_n_d;
            ale_q       <= ale_d;
            rd_n_q      <= rd_n_d;
            address_q   <= address_d;
            aod_q       <= aod_d;
            data_vga_q  <= data_vga_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
        end
    end

    // Outputs are decoded from the next state so the registered strobes line up with state_q.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_vga_d = data_vga_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.scan_req) begin
                    idx_d   = 4'd0;
                    cnt_d   = CNT_ADDR;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'h00) begin
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q - 8'h01;
                end
            end
            S_TURN: begin
                cnt_d   = CNT_RD;
                state_d = S_READ;
            end
            S_READ: begin
                if (cnt_q == 8'h00) begin
                    data_vga_d = bus.ad_in;
                    state_d    = S_CAPT;
                end else begin
                    cnt_d = cnt_q - 8'h01;
                end
            end
            S_CAPT: begin
                cnt_d   = CNT_GAP;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == 8'h00) begin
                    if (idx_q < 4'(LAST_IDX)) begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = CNT_ADDR;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'h01;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ad_out_d    = 8'h00;
        ad_oe_d     = 1'b0;
        ale_d       = 1'b0;
        rd_n_d      = 1'b1;
        aod_d       = 1'b1;
        address_d   = address_q;
        cs_n_d      = 1'b1;
        busy_d      = (state_d != S_IDLE);
        scan_done_d = (state_d == S_DONE);

        unique case (state_d)
            S_ADDR: begin
                cs_n_d    = 1'b0;
                ale_d     = 1'b1;
                ad_oe_d   = 1'b1;
                ad_out_d  = reg_addr(idx_d);
                address_d = reg_addr(idx_d);
            end
            S_TURN: cs_n_d = 1'b0;
            S_READ: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            S_CAPT: begin
                cs_n_d = 1'b0;
                aod_d  = 1'b0;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    assign bus.ad_out    = ad_out_q;
    assign bus.ad_oe     = ad_oe_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.ale       = ale_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.address   = address_q;
    assign bus.AoD       = aod_q;
    assign bus.data_vga  = data_vga_q;
    assign bus.busy      = busy_q;
    assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader with an RTC model that returns ~address on reads.
module tb_rtc_bus_reader;

    logic clk;
    logic reset_n;
    logic [7:0] rtc_addr_q;
    int n_checks;
    int n_fail;

    rtc_bus_reader_if bus ();

    rtc_bus_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC model: latch address on ale, return its complement while rd_n is low
    always @(posedge clk) begin
        if (bus.ale && bus.ad_oe) rtc_addr_q <= bus.ad_out;
    end
    assign bus.ad_in = bus.rd_n ? 8'hFF : ~rtc_addr_q;

    logic [7:0] exp_addr [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                                  8'h41, 8'h42, 8'h43};
    logic [7:0] exp_data [11] = '{8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hD8, 8'hD7,
                                  8'hBE, 8'hBD, 8'hBC};

    task automatic pulse_req();
        @(negedge clk);
        bus.scan_req = 1'b1;
        @(negedge clk);
        bus.scan_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.scan_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.ad_out !== 8'h00)   begin n_fail++; $display("FAIL reset_ad_out got %h want 00", bus.ad_out); end
        n_checks++; if (bus.ad_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_ad_oe got %b want 0", bus.ad_oe); end
        n_checks++; if (bus.cs_n !== 1'b1)      begin n_fail++; $display("FAIL reset_cs_n got %b want 1", bus.cs_n); end
        n_checks++; if (bus.ale !== 1'b0)       begin n_fail++; $display("FAIL reset_ale got %b want 0", bus.ale); end
        n_checks++; if (bus.rd_n !== 1'b1)      begin n_fail++; $display("FAIL reset_rd_n got %b want 1", bus.rd_n); end
        n_checks++; if (bus.address !== 8'h00)  begin n_fail++; $display("FAIL reset_address got %h want 00", bus.address); end
        n_checks++; if (bus.AoD !== 1'b1)       begin n_fail++; $display("FAIL reset_AoD got %b want 1", bus.AoD); end
        n_checks++; if (bus.data_vga !== 8'h00) begin n_fail++; $display("FAIL reset_data_vga got %h want 00", bus.data_vga); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done got %b want 0", bus.scan_done); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy got %b want 0", bus.busy); end
    endtask

    // Full scan with capture values, strobe widths and bus-safety invariants
    task automatic test_single_scan();
        int n, k, ale_run, rd_run, cs_run;
        logic done, prev_aod, prev_ale, prev_rd, prev_cs;
        pulse_req();
        n = 0; k = 0; ale_run = 0; rd_run = 0; cs_run = 0;
        done = 1'b0; prev_aod = 1'b1; prev_ale = 1'b0; prev_rd = 1'b1; prev_cs = 1'b1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            n++;
            if (n == 1) begin
                n_checks++; if (bus.ale !== 1'b1 || bus.ad_out !== 8'h21 || bus.address !== 8'h21) begin
                    n_fail++; $display("FAIL first_addr ale=%b ad_out=%h address=%h want 1/21/21", bus.ale, bus.ad_out, bus.address);
                end
            end
            n_checks++; if (bus.ad_oe === 1'b1 && bus.rd_n === 1'b0) begin
                n_fail++; $display("FAIL bus_contention cycle %0d ad_oe=1 rd_n=0", n);
            end
            n_checks++; if (bus.ale === 1'b1 && bus.ad_oe !== 1'b1) begin
                n_fail++; $display("FAIL ale_without_oe cycle %0d ad_oe=%b", n, bus.ad_oe);
            end
            if (bus.AoD === 1'b0) begin
                n_checks++; if (prev_aod === 1'b0) begin n_fail++; $display("FAIL aod_consecutive cycle %0d", n); end
                if (k < 11) begin
                    n_checks++; if (bus.address !== exp_addr[k] || bus.data_vga !== exp_data[k]) begin
                        n_fail++; $display("FAIL capture_%0d got %h/%h want %h/%h", k, bus.address, bus.data_vga, exp_addr[k], exp_data[k]);
                    end
                end else begin
                    n_checks++; n_fail++; $display("FAIL extra_capture got %0d want 11", k + 1);
                end
                k++;
            end
            if (bus.ale === 1'b1) ale_run++;
            else if (prev_ale === 1'b1) begin
                n_checks++; if (ale_run != 4) begin n_fail++; $display("FAIL ale_width got %0d want 4", ale_run); end
                ale_run = 0;
            end
            if (bus.rd_n === 1'b0) rd_run++;
            else if (prev_rd === 1'b0) begin
                n_checks++; if (rd_run != 6) begin n_fail++; $display("FAIL rd_width got %0d want 6", rd_run); end
                rd_run = 0;
            end
            if (bus.cs_n === 1'b1 && bus.busy === 1'b1) cs_run++;
            else if (bus.cs_n === 1'b0 && prev_cs === 1'b1 && cs_run > 0) begin
                n_checks++; if (cs_run != 4) begin n_fail++; $display("FAIL cs_gap got %0d want 4", cs_run); end
                cs_run = 0;
            end
            if (bus.scan_done === 1'b1) begin
                n_checks++; if (n != 177) begin n_fail++; $display("FAIL scan_len got %0d want 177", n); end
                n_checks++; if (k != 11) begin n_fail++; $display("FAIL capture_count got %0d want 11", k); end
                done = 1'b1;
            end
            prev_aod = bus.AoD; prev_ale = bus.ale; prev_rd = bus.rd_n; prev_cs = bus.cs_n;
            if (!done) @(negedge clk);
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL scan_timeout got no scan_done want pulse"); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.address !== 8'h43 || bus.data_vga !== 8'hBC) begin
            n_fail++; $display("FAIL post_scan_hold busy=%b address=%h data=%h want 0/43/BC", bus.busy, bus.address, bus.data_vga);
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        @(negedge clk);
        bus.scan_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.scan_done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout got no scan_done want pulse"); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle busy=%b cs_n=%b want 0/1", bus.busy, bus.cs_n);
        end
        @(negedge clk);
        n_checks++; if (bus.ale !== 1'b1 || bus.ad_out !== 8'h21 || bus.address !== 8'h21) begin
            n_fail++; $display("FAIL b2b_restart ale=%b ad_out=%h address=%h want 1/21/21", bus.ale, bus.ad_out, bus.address);
        end
        bus.scan_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.scan_done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_second_timeout got no scan_done want pulse"); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy=%b want 0", bus.busy); end
    endtask

    task automatic test_busy_ignore();
        logic seen;
        int dones, caps;
        pulse_req();
        seen = 1'b0;
        dones = 0; caps = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.AoD === 1'b0) caps++;
            if (bus.ale === 1'b1 && bus.address === 8'h25) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL ignore_reach_25 got timeout want address 25"); end
        bus.scan_req = 1'b1;
        @(negedge clk);
        bus.scan_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.AoD === 1'b0) caps++;
            if (bus.scan_done === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        n_checks++; if (caps != 11) begin n_fail++; $display("FAIL ignore_capture_count got %0d want 11", caps); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_final_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        logic seen;
        pulse_req();
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.rd_n === 1'b0 && bus.address === 8'h42) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_reach_42 got timeout want READ of 42"); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.rd_n !== 1'b1 || bus.cs_n !== 1'b1 || bus.AoD !== 1'b1) begin
            n_fail++; $display("FAIL abort_immediate rd_n=%b cs_n=%b AoD=%b want 1/1/1", bus.rd_n, bus.cs_n, bus.AoD);
        end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.AoD !== 1'b1 || bus.data_vga !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_capture AoD=%b data=%h busy=%b want 1/00/0", bus.AoD, bus.data_vga, bus.busy);
        end
        reset_n = 1'b1;
        @(negedge clk);
        pulse_req();
        n_checks++; if (bus.ale !== 1'b1 || bus.ad_out !== 8'h21 || bus.address !== 8'h21) begin
            n_fail++; $display("FAIL abort_restart ale=%b ad_out=%h address=%h want 1/21/21", bus.ale, bus.ad_out, bus.address);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.AoD === 1'b0) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.address !== 8'h21 || bus.data_vga !== 8'hDE) begin
            n_fail++; $display("FAIL abort_first_capture seen=%b address=%h data=%h want 1/21/DE", seen, bus.address, bus.data_vga);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b0;
        bus.scan_req = 1'b0;
        test_reset();
        test_single_scan();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
